// File: rtl/circ_shift_reg_pkg.sv
// Shared encodings for the circular shift register: FSM states and rotation direction.
package circ_shift_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/circ_shift_reg_if.sv
// Control/data bundle between a controller (master) and the circular shift register (slave).
interface circ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             step_in;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             start;
    logic             stop;
    logic             dir;
    logic [CNT_W-1:0] num_steps;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] step_count;

    modport master (
        output step_in, load, load_data, start, stop, dir, num_steps,
        input  data_out, busy, done, step_count
    );

    modport slave (
        input  step_in, load, load_data, start, stop, dir, num_steps,
        output data_out, busy, done, step_count
    );
endinterface

// File: rtl/circ_shift_reg_step_edge_det.sv
// Single-bit rising-edge detector; the history flop's reset value is configurable so a
// level that is already high when reset releases does not produce a tick.
module step_edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic sys_clk_in,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);
    logic sig_reg;

    always_ff @(posedge sys_clk_in or posedge reset) begin
        if (reset) begin
            sig_reg <= RST_VAL;
        end else begin
            sig_reg <= sig_in;
        end
    end

    assign rise = sig_in & ~sig_reg;

endmodule

// File: rtl/circ_shift_reg.sv
// Circular shift register stepped by rising edges of a divided-clock level, with
// parallel load, start/stop control and an optional step budget that ends in a done pulse.
module circ_shift_reg
    import circ_shift_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               CNT_W = 8
) (
    input  logic              sys_clk_in,
    input  logic              reset,
    circ_shift_reg_if.slave   bus
);
    state_t           state_reg, state_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [WIDTH-1:0] rot_left, rot_right;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] lim_reg, lim_next;
    logic [CNT_W-1:0] count_inc;
    logic             tick;

    step_edge_det #(
        .RST_VAL (1'b1)
    ) u_step_det (
        .sys_clk_in (sys_clk_in),
        .reset      (reset),
        .sig_in     (bus.step_in),
        .rise       (tick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign rot_left[gi]  = data_reg[(gi + WIDTH - 1) % WIDTH];
            assign rot_right[gi] = data_reg[(gi + 1) % WIDTH];
        end
    endgenerate

    assign count_inc = count_reg + 1'b1;

    always_ff @(posedge sys_clk_in or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            data_reg  <= INIT;
            count_reg <= '0;
            lim_reg   <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            count_reg <= count_next;
            lim_reg   <= lim_next;
        end
    end

    // load beats stop beats start beats tick; the losers are simply dropped this cycle.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        count_next = count_reg;
        lim_next   = lim_reg;
        if (bus.load) begin
            data_next  = bus.load_data;
            count_next = '0;
            state_next = S_IDLE;
        end else if (bus.stop) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        state_next = S_RUN;
                        count_next = '0;
                        lim_next   = bus.num_steps;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        data_next  = (bus.dir == DIR_RIGHT) ? rot_right : rot_left;
                        count_next = count_inc;
                        if ((lim_reg != '0) && (count_inc == lim_reg)) begin
                            state_next = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out   = data_reg;
    assign bus.busy       = (state_reg == S_RUN);
    assign bus.done       = (state_reg == S_DONE);
    assign bus.step_count = count_reg;

endmodule

// File: tb/tb_circ_shift_reg.sv
// Scenario bench for circ_shift_reg: expected register values are queued when stimulus is
// driven and popped when the result is observed.
module tb_circ_shift_reg;
    import circ_shift_pkg::*;

    logic       sys_clk_in = 1'b0;
    logic       reset      = 1'b1;
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_data;
    logic [7:0] model;
    logic       done_seen;

    circ_shift_reg_if #(.WIDTH(8), .CNT_W(8)) bus ();

    circ_shift_reg #(
        .WIDTH (8),
        .INIT  (8'h01),
        .CNT_W (8)
    ) dut (
        .sys_clk_in (sys_clk_in),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 sys_clk_in = ~sys_clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] rotl(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] v);
        return {v[0], v[7:1]};
    endfunction

    task automatic idle_inputs();
        bus.step_in   = 1'b0;
        bus.load      = 1'b0;
        bus.load_data = 8'h00;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.dir       = DIR_LEFT;
        bus.num_steps = 8'd0;
    endtask

    task automatic do_load(input logic [7:0] v);
        @(negedge sys_clk_in);
        bus.load      = 1'b1;
        bus.load_data = v;
        @(negedge sys_clk_in);
        bus.load      = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] n, input logic d);
        @(negedge sys_clk_in);
        bus.num_steps = n;
        bus.dir       = d;
        bus.start     = 1'b1;
        @(negedge sys_clk_in);
        bus.start     = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge sys_clk_in);
        bus.stop = 1'b1;
        @(negedge sys_clk_in);
        bus.stop = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge sys_clk_in);
        bus.step_in = 1'b1;
        @(negedge sys_clk_in);
        done_seen   = done_seen | bus.done;
        bus.step_in = 1'b0;
        @(negedge sys_clk_in);
        done_seen   = done_seen | bus.done;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (4) begin
            @(negedge sys_clk_in);
            bus.step_in = ~bus.step_in;
        end
        vectors++;
        if (bus.data_out !== 8'h01 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_hold: data=%h busy=%b done=%b cnt=%0d expected data=01 busy=0 done=0 cnt=0",
                     bus.data_out, bus.busy, bus.done, bus.step_count);
        end
        @(negedge sys_clk_in);
        reset = 1'b0;
        exp_q.push_back(8'h01);
        repeat (6) begin
            @(negedge sys_clk_in);
            bus.step_in = ~bus.step_in;
        end
        @(negedge sys_clk_in);
        bus.step_in = 1'b0;
        @(negedge sys_clk_in);
        exp_data = exp_q.pop_front();
        vectors++;
        if (bus.data_out !== exp_data || bus.busy !== 1'b0 || bus.step_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_no_start: data=%h busy=%b cnt=%0d expected data=%h busy=0 cnt=0",
                     bus.data_out, bus.busy, bus.step_count, exp_data);
        end
        $display("test_reset: data_out=%h busy=%b", bus.data_out, bus.busy);
    endtask

    task automatic test_left_budget();
        do_load(8'h81);
        model = 8'h81;
        do_start(8'd3, DIR_LEFT);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL left_busy: busy=%b expected 1", bus.busy);
        end
        for (int i = 0; i < 3; i++) begin
            model = rotl(model);
            exp_q.push_back(model);
            @(negedge sys_clk_in);
            bus.step_in = 1'b1;
            @(negedge sys_clk_in);
            bus.step_in = 1'b0;
            exp_data = exp_q.pop_front();
            vectors++;
            if (bus.data_out !== exp_data || bus.done !== (i == 2) || bus.busy !== (i != 2)) begin
                miscompares++;
                $display("FAIL left_step[%0d]: data=%h done=%b busy=%b expected data=%h done=%b busy=%b",
                         i, bus.data_out, bus.done, bus.busy, exp_data, (i == 2), (i != 2));
            end
            @(negedge sys_clk_in);
            vectors++;
            if (bus.done !== 1'b0 || bus.busy !== (i != 2)) begin
                miscompares++;
                $display("FAIL left_after[%0d]: done=%b busy=%b expected done=0 busy=%b",
                         i, bus.done, bus.busy, (i != 2));
            end
            $display("left step %0d: data_out=%h done=%b", i, exp_data, (i == 2));
        end
        vectors++;
        if (bus.step_count !== 8'd3) begin
            miscompares++;
            $display("FAIL left_count: step_count=%0d expected 3", bus.step_count);
        end
        exp_q.push_back(model);
        pulse_step();
        pulse_step();
        exp_data = exp_q.pop_front();
        vectors++;
        if (bus.data_out !== exp_data || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL left_post_done: data=%h busy=%b expected data=%h busy=0",
                     bus.data_out, bus.busy, exp_data);
        end
    endtask

    task automatic test_right_continuous();
        do_load(8'h01);
        model = 8'h01;
        do_start(8'd0, DIR_RIGHT);
        done_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            model = rotr(model);
            exp_q.push_back(model);
            pulse_step();
            exp_data = exp_q.pop_front();
            vectors++;
            if (bus.data_out !== exp_data || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL right_step[%0d]: data=%h busy=%b expected data=%h busy=1",
                         i, bus.data_out, bus.busy, exp_data);
            end
            $display("right step %0d: data_out=%h", i, exp_data);
        end
        vectors++;
        if (bus.step_count !== 8'd8 || done_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL right_summary: step_count=%0d done_seen=%b expected 8 and 0",
                     bus.step_count, done_seen);
        end
        do_stop();
    endtask

    task automatic test_wrap();
        do_load(8'h01);
        model = 8'h01;
        do_start(8'd0, DIR_LEFT);
        done_seen = 1'b0;
        for (int i = 0; i < 256; i++) begin
            model = rotl(model);
            pulse_step();
        end
        exp_q.push_back(model);
        exp_data = exp_q.pop_front();
        vectors++;
        if (bus.step_count !== 8'd0 || bus.data_out !== exp_data || bus.busy !== 1'b1 || done_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap: cnt=%0d data=%h busy=%b done_seen=%b expected cnt=0 data=%h busy=1 done_seen=0",
                     bus.step_count, bus.data_out, bus.busy, done_seen, exp_data);
        end
        $display("wrap: 256 steps, step_count=%0d data_out=%h", bus.step_count, bus.data_out);
        do_stop();
    endtask

    task automatic test_edge_hold();
        do_load(8'h01);
        model = 8'h01;
        do_start(8'd0, DIR_LEFT);
        model = rotl(model);
        exp_q.push_back(model);
        @(negedge sys_clk_in);
        bus.step_in = 1'b1;
        repeat (10) @(negedge sys_clk_in);
        bus.step_in = 1'b0;
        repeat (2) @(negedge sys_clk_in);
        exp_data = exp_q.pop_front();
        vectors++;
        if (bus.data_out !== exp_data || bus.step_count !== 8'd1) begin
            miscompares++;
            $display("FAIL edge_hold: data=%h cnt=%0d expected data=%h cnt=1",
                     bus.data_out, bus.step_count, exp_data);
        end
        $display("edge_hold: data_out=%h step_count=%0d", bus.data_out, bus.step_count);
    endtask

    task automatic test_simultaneous();
        // Still running from test_edge_hold: a second start must not restart or clear.
        do_start(8'd5, DIR_LEFT);
        model = rotl(model);
        exp_q.push_back(model);
        pulse_step();
        exp_data = exp_q.pop_front();
        vectors++;
        if (bus.data_out !== exp_data || bus.step_count !== 8'd2 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_in_run: data=%h cnt=%0d busy=%b expected data=%h cnt=2 busy=1",
                     bus.data_out, bus.step_count, bus.busy, exp_data);
        end
        exp_q.push_back(model);
        @(negedge sys_clk_in);
        bus.step_in = 1'b1;
        bus.stop    = 1'b1;
        @(negedge sys_clk_in);
        bus.step_in = 1'b0;
        bus.stop    = 1'b0;
        @(negedge sys_clk_in);
        exp_data = exp_q.pop_front();
        vectors++;
        if (bus.data_out !== exp_data || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_count !== 8'd2) begin
            miscompares++;
            $display("FAIL stop_vs_tick: data=%h busy=%b done=%b cnt=%0d expected data=%h busy=0 done=0 cnt=2",
                     bus.data_out, bus.busy, bus.done, bus.step_count, exp_data);
        end
        do_start(8'd0, DIR_LEFT);
        pulse_step();
        exp_q.push_back(8'hA5);
        @(negedge sys_clk_in);
        bus.step_in   = 1'b1;
        bus.load      = 1'b1;
        bus.load_data = 8'hA5;
        @(negedge sys_clk_in);
        bus.step_in = 1'b0;
        bus.load    = 1'b0;
        @(negedge sys_clk_in);
        exp_data = exp_q.pop_front();
        vectors++;
        if (bus.data_out !== exp_data || bus.busy !== 1'b0 || bus.step_count !== 8'd0) begin
            miscompares++;
            $display("FAIL load_vs_tick: data=%h busy=%b cnt=%0d expected data=%h busy=0 cnt=0",
                     bus.data_out, bus.busy, bus.step_count, exp_data);
        end
        $display("simultaneous: data_out=%h busy=%b", bus.data_out, bus.busy);
    endtask

    task automatic test_reset_mid_run();
        do_load(8'h01);
        model = 8'h01;
        do_start(8'd0, DIR_LEFT);
        for (int i = 0; i < 2; i++) begin
            model = rotl(model);
            pulse_step();
        end
        exp_q.push_back(model);
        exp_data = exp_q.pop_front();
        vectors++;
        if (bus.data_out !== exp_data) begin
            miscompares++;
            $display("FAIL pre_reset: data=%h expected %h", bus.data_out, exp_data);
        end
        @(negedge sys_clk_in);
        #2;
        reset       = 1'b1;
        bus.step_in = 1'b1;
        #1;
        vectors++;
        if (bus.data_out !== 8'h01 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_count !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset: data=%h busy=%b done=%b cnt=%0d expected data=01 busy=0 done=0 cnt=0",
                     bus.data_out, bus.busy, bus.done, bus.step_count);
        end
        @(negedge sys_clk_in);
        reset = 1'b0;
        model = 8'h01;
        do_start(8'd0, DIR_LEFT);
        repeat (3) @(negedge sys_clk_in);
        exp_q.push_back(model);
        exp_data = exp_q.pop_front();
        vectors++;
        if (bus.data_out !== exp_data || bus.busy !== 1'b1 || bus.step_count !== 8'd0) begin
            miscompares++;
            $display("FAIL release_high: data=%h busy=%b cnt=%0d expected data=%h busy=1 cnt=0",
                     bus.data_out, bus.busy, bus.step_count, exp_data);
        end
        bus.step_in = 1'b0;
        @(negedge sys_clk_in);
        model = rotl(model);
        exp_q.push_back(model);
        pulse_step();
        exp_data = exp_q.pop_front();
        vectors++;
        if (bus.data_out !== exp_data || bus.step_count !== 8'd1) begin
            miscompares++;
            $display("FAIL fresh_edge: data=%h cnt=%0d expected data=%h cnt=1",
                     bus.data_out, bus.step_count, exp_data);
        end
        $display("reset_mid_run: data_out=%h step_count=%0d", bus.data_out, bus.step_count);
    endtask

    initial begin
        done_seen = 1'b0;
        test_reset();
        test_left_budget();
        test_right_continuous();
        test_wrap();
        test_edge_hold();
        test_simultaneous();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/circ_shift_reg.md
Name: circ_shift_reg

Overview:
- Circular (rotate) shift register that consumes the divided-clock output of the team's clock divider and rotates its contents one position per divided-clock rising edge.
- Runs entirely on the system clock. The divider output enters as a level signal and is edge-detected internally into a one-cycle step tick.
- Supports parallel load, left/right rotation, start/stop control, and an optional bounded step count with a done pulse. Drives LED/display patterns in lab designs.

Parameters:
WIDTH, 8, register width in bits (>=2)
INIT, 8'h01, data_out value at reset (WIDTH bits)
CNT_W, 8, width of step counter and num_steps

Ports:
sys_clk_in  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
step_in  input  1  divided-clock level from clock divider, synchronous to sys_clk_in
load  input  1  parallel-load strobe
load_data  input  WIDTH  value captured on load
start  input  1  begin rotating
stop  input  1  halt rotating
dir  input  1  0 = rotate left (MSB wraps to LSB), 1 = rotate right (LSB wraps to MSB)
num_steps  input  CNT_W  step budget latched at start; 0 = continuous
data_out  output  WIDTH  register contents
busy  output  1  high in RUN
done  output  1  one-cycle pulse when step budget is exhausted
step_count  output  CNT_W  shifts performed since last start

Behaviour:
- Interface: one clock (sys_clk_in). reset is asynchronous and active-high.
- Reset values:
  - data_out = INIT
  - step_count = 0
  - busy = 0
  - done = 0
  - state = IDLE
  - step_q = 1, which suppresses a spurious tick if step_in is high when reset releases.
- Edge detect: step_q <= step_in every cycle. tick = step_in & ~step_q. A step_in high for N cycles yields exactly one tick.
- Latency: the shift occurs on the first sys_clk_in edge at which step_in=1 and step_q=0. data_out is valid the cycle after step_in rises.
- States:
  - IDLE: data_out held. busy = 0.
  - RUN: busy = 1. On tick, data_out rotates by 1 per dir (dir sampled every tick; changing dir mid-run is legal) and step_count increments.
  - DONE: single cycle. done = 1, busy = 0. Then goes to IDLE.
- Transitions:
  - IDLE -> RUN on start. Clears step_count and latches num_steps into steps_lim.
  - RUN -> IDLE on stop. No done pulse; step_count retained.
  - RUN -> DONE on a tick when steps_lim != 0 and step_count+1 == steps_lim. That final shift is applied.
  - DONE -> IDLE unconditionally.
- Priority in any state, per cycle: load > stop > start > tick.
  - load: data_out <= load_data, step_count <= 0, state <= IDLE, no done. Any tick in that cycle is discarded.
  - stop with start or tick in the same cycle: no shift, no start.
  - start while already in RUN: ignored, no restart and no counter clear.
  - start in DONE: ignored.
- Continuous mode (steps_lim = 0): step_count wraps from 2^CNT_W-1 to 0. It never enters DONE.
- Rotation is pure. No bits are lost or inserted, so popcount(data_out) is invariant between loads.
- Reset mid-RUN: all outputs return to reset values immediately (asynchronously). After reset releases, no shift occurs until a fresh rising edge of step_in.

Decomposition:
- Package circ_shift_pkg holds:
  - state encoding localparams S_IDLE, S_RUN, S_DONE (2-bit)
  - DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1
- Sub-module step_edge_det (1-bit rising-edge detector with configurable reset value for step_q) is reused later for button inputs.
- Rotation and FSM stay in circ_shift_reg.

Test Plan:
1. Reset with defaults, step_in toggling -> data_out=8'h01, busy=0, done=0, step_count=0, no shift until start.
2. Left rotation with budget: load 8'h81; dir=0, num_steps=3, start; 3 step_in rising edges ->
   - data_out = 8'h03, 8'h06, 8'h0C, one per edge
   - done = 1 for exactly one cycle after the third shift, then busy = 0
   - further step_in edges leave data_out = 8'h0C
3. Continuous right rotation: load 8'h01, dir=1, num_steps=0, start; 8 step_in edges ->
   - data_out = 80, 40, 20, 10, 08, 04, 02, 01
   - step_count = 8, busy stays 1, done never asserted
4. Edge detection: in RUN, hold step_in high for 10 cycles, then low -> exactly one shift.
5. Simultaneous events:
   - stop asserted on the same cycle as a tick -> no shift, IDLE, done = 0.
   - load 8'hA5 on the same cycle as a tick in RUN -> data_out = 8'hA5, IDLE, step_count = 0.
6. Reset mid-RUN: assert reset asynchronously after 2 shifts, then release with step_in=1 ->
   - outputs return to reset values immediately
   - no shift on release
   - the first shift occurs only after step_in falls and rises again
